// File: rtl/qsys_key_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, register map
// and small helpers used by the scanner and its key-code FIFO.
package qsys_key_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DEB_P = 3'd2,
    PUSH  = 3'd3,
    HELD  = 3'd4,
    DEB_R = 3'd5
  } key_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQEN  = 2'd2;

  // Index of the lowest-numbered low column (0 when none is low).
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] row);
    return 4'b0001 << row;
  endfunction

  // The STATUS count field is 4 bits wide; a full 16-deep queue reads as 15.
  function automatic logic [3:0] sat_count(input logic [4:0] cnt);
    return (cnt > 5'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key-code FIFO. Pops of an empty queue are ignored; a push into a
// full queue is accepted only when a pop frees a slot in the same cycle.
module key_fifo
  import qsys_key_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [CODE_W-1:0] din,
  input  logic              pop,
  output logic [CODE_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding a stale value (which would infer a latch).
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count define validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/qsys_key_scan.sv
// Avalon-MM 4x4 keypad scanner: open-drain row drive, synchronised column sense,
// tick-paced scan/debounce FSM, key-code FIFO and a four-register slave.
module qsys_key_scan
  import qsys_key_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  inout  wire  [7:0]  bidir_port
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_TICKS + 1);
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [3:0]       col_meta_q, col_sync_q;
  key_state_e       state_q;
  logic [1:0]       row_q, col_q;
  logic [DEB_W-1:0] deb_q;
  logic [3:0]       row_drv_q;
  logic [31:0]      rdata_q;
  logic             ovf_q, irq_en_q;

  logic             any_low, latched_low, rd_en, wr_en, fifo_pop, push;
  logic [CODE_W-1:0] fifo_dout;
  logic [FAW:0]     fifo_count;
  logic             fifo_full, fifo_empty;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:1];

  // Rows are open-drain: pull low or release; columns are sensed only.
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign bidir_port[i] = row_drv_q[i] ? 1'b0 : 1'bz;
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      col_meta_q <= bidir_port[7:4];
      col_sync_q <= col_meta_q;
    end
  end

  assign any_low     = ~&col_sync_q;
  assign latched_low = ~col_sync_q[col_q];
  assign push        = (state_q == PUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      deb_q     <= '0;
      row_drv_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          row_drv_q <= 4'hF;
          if (tick && any_low) begin
            state_q   <= SCAN;
            row_q     <= 2'd0;
            row_drv_q <= row_onehot(2'd0);
          end
        end
        SCAN: if (tick) begin
          if (any_low) begin
            state_q <= DEB_P;
            col_q   <= lowest_low(col_sync_q);
            deb_q   <= '0;
          end else if (row_q == 2'd3) begin
            state_q   <= IDLE;
            row_drv_q <= 4'hF;
          end else begin
            row_q     <= row_q + 2'd1;
            row_drv_q <= row_onehot(row_q + 2'd1);
          end
        end
        DEB_P: if (tick) begin
          if (!latched_low) begin
            state_q   <= IDLE;
            row_drv_q <= 4'hF;
          end else if (deb_q == DEB_LAST) begin
            state_q <= PUSH;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        PUSH: state_q <= HELD;
        HELD: if (tick && !latched_low) begin
          state_q <= DEB_R;
          deb_q   <= '0;
        end
        DEB_R: if (tick) begin
          if (latched_low) begin
            state_q <= HELD;
          end else if (deb_q == DEB_LAST) begin
            state_q   <= IDLE;
            row_drv_q <= 4'hF;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          row_drv_q <= 4'hF;
        end
      endcase
    end
  end

  assign rd_en    = chipselect & ~read_n;
  assign wr_en    = chipselect & ~write_n;
  assign fifo_pop = rd_en & (address == ADDR_DATA);

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     ({row_q, col_q}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (rd_en) begin
        case (address)
          ADDR_DATA:   rdata_q <= fifo_empty ? '0 : {1'b1, 27'd0, fifo_dout};
          ADDR_STATUS: rdata_q <= {23'd0, ovf_q, sat_count(5'(fifo_count)), 1'b0, state_q};
          ADDR_IRQEN:  rdata_q <= {31'd0, irq_en_q};
          default:     rdata_q <= '0;
        endcase
      end
      if (wr_en && address == ADDR_STATUS && writedata[0]) ovf_q <= 1'b0;
      if (wr_en && address == ADDR_IRQEN) irq_en_q <= writedata[0];
      // A dropped code outranks a same-cycle clear so the loss is never hidden.
      if (push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_en_q & ~fifo_empty;

endmodule

// File: tb/tb_qsys_key_scan.sv
// Directed and randomized bench for qsys_key_scan with a resistive keypad model
// and a queue-level reference of the key-code FIFO, overflow and interrupt.
module tb_qsys_key_scan;
  import qsys_key_pkg::*;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_TICKS  = 3;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  wire  [7:0]  bidir_port;

  logic [15:0] pressed = '0;
  logic [3:0]  col_drive = 4'hF;

  int total = 0;
  int bad   = 0;
  int model_q[$];
  bit model_ovf = 1'b0;
  bit model_irq_en = 1'b0;

  qsys_key_scan #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (bidir_port)
  );

  always #5 clk = ~clk;

  // Released rows float high through the board pull-ups.
  for (genvar i = 0; i < 4; i++) begin : g_pull
    pullup (bidir_port[i]);
  end
  assign bidir_port[7:4] = col_drive;

  // A closed switch shorts its column to its row; an undriven row leaves the column pulled high.
  always @(negedge clk) begin
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (pressed[r*4+k] && bidir_port[r] == 1'b0) c[k] = 1'b0;
    col_drive = c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * SCAN_DIV) @(posedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Scan order is row 0 upwards, and within the first hit row the lowest column wins.
  function automatic int expected_code(input logic [15:0] keys);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keys[r*4+k]) return r * 4 + k;
    return -1;
  endfunction

  function automatic void model_press(input int code);
    if (code < 0) return;
    if (model_q.size() == FIFO_DEPTH) model_ovf = 1'b1;
    else model_q.push_back(code);
  endfunction

  function automatic logic [31:0] model_status();
    return {23'd0, model_ovf, 4'(model_q.size()), 4'd0};
  endfunction

  task automatic press(input logic [15:0] keys, input int hold);
    pressed = keys;
    ticks(hold);
    model_press(expected_code(keys));
    pressed = '0;
    ticks(7);
  endtask

  task automatic check_data(input string tag);
    logic [31:0] d, exp;
    rd(ADDR_DATA, d);
    if (model_q.size() > 0) exp = {1'b1, 27'd0, 4'(model_q.pop_front())};
    else exp = '0;
    check(tag, d, exp);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    rd(ADDR_STATUS, d);
    check(tag, d, model_status());
  endtask

  task automatic check_irq(input string tag);
    check(tag, {31'd0, irq}, {31'd0, model_irq_en && model_q.size() > 0});
  endtask

  initial begin
    logic [31:0] d;
    int          keys[$];
    int          k, exp_old;
    bit          found;

    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rows_released", {28'd0, bidir_port[3:0]}, 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rows_all_low", {28'd0, bidir_port[3:0]}, 32'h0);
    check_status("reset_status");
    rd(ADDR_IRQEN, d);
    check("reset_irq_en", d, 32'd0);
    rd(2'd3, d);
    check("addr3_reads_zero", d, 32'd0);

    // Single press of row 2 / column 1.
    press(16'd1 << 9, 10);
    check_status("t1_status");
    check_irq("t1_irq_disabled");
    wr(ADDR_IRQEN, 32'd1);
    model_irq_en = 1'b1;
    #1;
    check_irq("t1_irq_enabled");
    rd(ADDR_IRQEN, d);
    check("t1_irq_en_reg", d, 32'd1);
    check_data("t1_data_first");
    check_irq("t1_irq_after_pop");
    check_data("t1_data_empty");

    // Bouncing contact never settles long enough to debounce.
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? (16'd1 << 5) : 16'd0;
      ticks(1);
    end
    ticks(1);
    pressed = '0;
    ticks(7);
    check_status("t2_bounce_idle");

    // Five distinct random keys, no reads: fourth fills the queue, fifth overflows.
    while (keys.size() < 5) begin
      k = $urandom_range(0, 15);
      if (!(k inside {keys})) keys.push_back(k);
    end
    foreach (keys[i]) press(16'd1 << keys[i], 12);
    check_status("t3_full_overflow");
    check_irq("t3_irq");
    wr(ADDR_STATUS, 32'd1);
    model_ovf = 1'b0;
    check_status("t3_ovf_cleared");
    rd(ADDR_IRQEN, d);
    check("t3_irq_en_kept", d, 32'd1);

    // Pop lands on the same clock as the push into the full queue.
    k = $urandom_range(0, 15);
    pressed = 16'd1 << k;
    found = 1'b0;
    for (int i = 0; i < 40 * SCAN_DIV && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == PUSH) found = 1'b1;
    end
    check("t4_push_seen", {31'd0, found}, 32'd1);
    address = ADDR_DATA; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
    exp_old = model_q.pop_front();
    model_q.push_back(k);
    check("t4_oldest_returned", readdata, {1'b1, 27'd0, 4'(exp_old)});
    pressed = '0;
    ticks(7);
    check_status("t4_count_kept");
    for (int i = 0; i < FIFO_DEPTH; i++) check_data("t4_drain");
    check_data("t4_drained_empty");

    // Two keys on row 0 held together.
    press((16'd1 << 0) | (16'd1 << 2), 12);
    check_data("t5_lowest_column");
    check_data("t5_single_code");

    // Randomized presses, including chords, with interleaved reads.
    for (int n = 0; n < 8; n++) begin
      logic [15:0] chord;
      chord = 16'd1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) chord |= 16'd1 << $urandom_range(0, 15);
      press(chord, $urandom_range(12, 18));
      check_irq("rand_irq");
      if ($urandom_range(0, 1) == 1) check_data("rand_data");
    end
    check_status("rand_status");
    while (model_q.size() > 0) check_data("rand_drain");
    check_data("rand_empty");

    // Reset asserted while a press is being debounced.
    press(16'd1 << 6, 12);
    rd(ADDR_STATUS, d);
    k = $urandom_range(0, 15);
    pressed = 16'd1 << k;
    found = 1'b0;
    for (int i = 0; i < 40 * SCAN_DIV && !found; i++) begin
      @(negedge clk);
      if (dut.state_q == DEB_P) found = 1'b1;
    end
    check("t6_debp_seen", {31'd0, found}, 32'd1);
    check_irq("t6_irq_before");
    reset_n = 1'b0;
    #1;
    check("t6_rows_released", {28'd0, bidir_port[3:0]}, 32'hF);
    check("t6_readdata", readdata, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    check("t6_count", 32'(dut.fifo_count), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    model_irq_en = 1'b0;
    pressed = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(3);
    check_status("t6_status_after");
    check_data("t6_data_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
